// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit between execute and writeback: one request at a time, word-aligned
// bus access with byte-lane store shaping and load extraction, plus a response timeout.
module ysyx_24110015_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_wen,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wmask,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       wmask_q;
  logic             wen_q;
  logic [2:0]       funct3_q;
  logic [CNT_W-1:0] cnt;

  logic             is_mem, illegal;
  logic [31:0]      shaped_wdata;
  logic [3:0]       shaped_wmask;
  logic [31:0]      load_val;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  assign in_ready  = (state == IDLE);
  assign req_valid = (state == REQ);
  assign out_valid = (state == DONE);
  assign req_addr  = {addr_q[31:2], 2'b00};
  assign req_wen   = wen_q;
  assign req_wdata = wdata_q;
  assign req_wmask = wmask_q;

  assign is_mem = in_ren | in_wen;

  // Only memory ops are screened; a pass-through ignores funct3 entirely.
  always_comb begin
    illegal = 1'b0;
    if (in_ren && in_wen) illegal = 1'b1;
    unique case (in_funct3)
      3'b000: ;
      3'b001: if (in_addr[0]) illegal = 1'b1;
      3'b010: if (in_addr[1:0] != 2'b00) illegal = 1'b1;
      3'b100: if (in_wen) illegal = 1'b1;
      3'b101: if (in_wen || in_addr[0]) illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    shaped_wdata = in_wdata;
    shaped_wmask = 4'b1111;
    unique case (in_funct3[1:0])
      2'b00: begin
        shaped_wdata = {4{in_wdata[7:0]}};
        shaped_wmask = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        shaped_wdata = {2{in_wdata[15:0]}};
        shaped_wmask = 4'b0011 << in_addr[1:0];
      end
      default: ;
    endcase
  end

  assign byte_v = resp_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = addr_q[1] ? resp_rdata[31:16] : resp_rdata[15:0];

  always_comb begin
    unique case (funct3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = resp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = (!is_mem || illegal) ? DONE : REQ;
      REQ:  if (req_ready) state_nxt = WAIT;
      WAIT: if (resp_valid || cnt == CNT_LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; resp_valid only matters while in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wen_q    <= 1'b0;
      funct3_q <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          addr_q   <= in_addr;
          wdata_q  <= shaped_wdata;
          wmask_q  <= in_wen ? shaped_wmask : 4'b0000;
          wen_q    <= in_wen;
          funct3_q <= in_funct3;
          out_data <= is_mem ? 32'h0 : in_addr;
          out_err  <= is_mem && illegal;
        end
        REQ: if (req_ready) cnt <= '0;
        WAIT: begin
          if (resp_valid) begin
            out_data <= wen_q ? 32'h0 : load_val;
            out_err  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            out_data <= 32'h0;
            out_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
